// File: rtl/buf_192x128_arb_pkg.sv
// Shared constants and grant encoding for the 192x128 buffer RAM front end.
package buf_192x128_arb_pkg;
  localparam int DEPTH      = 192;
  localparam int ADR_WD     = 8;
  localparam int DAT_WD     = 128;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_WD     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } gnt_e;

  function automatic logic adr_ok(input logic [ADR_WD-1:0] adr);
    return adr < ADR_WD'(DEPTH);
  endfunction
endpackage

// File: rtl/buf_192x128_arb_fifo.sv
// Read-return FIFO. Head is always presented on head_dat; pop is ignored when
// empty. Push and pop may coincide at any occupancy, including full. The
// storage is reset so the head reads zero out of reset.
// Ports: gclk/grst_n, push/push_dat, pop, head_dat/head_vld, cnt (occupancy).
module buf_192x128_arb_fifo #(
  parameter int DEPTH  = 4,
  parameter int W      = 128,
  parameter int CNT_WD = 3
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              push,
  input  logic [W-1:0]      push_dat,
  input  logic              pop,
  output logic [W-1:0]      head_dat,
  output logic              head_vld,
  output logic [CNT_WD-1:0] cnt
);
  localparam int PTR_WD = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_WD-1:0]       wptr, rptr;
  logic                    pop_ok;

  function automatic logic [PTR_WD-1:0] nxt(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + PTR_WD'(1);
  endfunction

  assign head_vld = (cnt != '0);
  assign head_dat = mem[rptr];
  assign pop_ok   = pop & head_vld;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_dat;
        wptr      <= nxt(wptr);
      end
      if (pop_ok) rptr <= nxt(rptr);
      cnt <= cnt + CNT_WD'(push) - CNT_WD'(pop_ok);
    end
  end
endmodule

// File: rtl/buf_192x128_arb.sv
// Arbiter between one masked-write client and one read client onto the single
// port of the 192x128 bit-enable buffer RAM, with an in-order read-return FIFO.
// Ports: gclk/grst_n; wr_* write request channel (req/adr/msk/dat, ack);
// rd_* read request channel (req/adr, ack) and return channel (val/dat/rdy);
// ram_* registered RAM command and RAM read data; err_o out-of-range pulse.
module buf_192x128_arb
  import buf_192x128_arb_pkg::*;
(
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              wr_req_i,
  input  logic [ADR_WD-1:0] wr_adr_i,
  input  logic [DAT_WD-1:0] wr_msk_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADR_WD-1:0] rd_adr_i,
  output logic              rd_ack_o,
  output logic              rd_val_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  input  logic              rd_rdy_i,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic [DAT_WD-1:0] ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i,
  output logic              err_o
);
  localparam int STAGES = 1;

  // vld_pipe[0]: read command cycle, vld_pipe[1]: RAM data cycle (push).
  // zero_pipe marks out-of-range reads that return zeros in order.
  logic [STAGES:0]   vld_pipe, zero_pipe;
  logic [CNT_WD-1:0] fifo_cnt;
  logic [CNT_WD:0]   credit;
  logic              rd_elig, wr_gnt, rd_gnt, wr_ok, rd_ok;
  gnt_e              last_gnt;

  // Occupancy plus in-flight reads bounds what the FIFO could ever receive,
  // so a push can never overflow even with the consumer stalled.
  assign credit  = (CNT_WD+1)'(fifo_cnt) + (CNT_WD+1)'(vld_pipe[0])
                 + (CNT_WD+1)'(vld_pipe[1]);
  assign rd_elig = rd_req_i & (credit < (CNT_WD+1)'(FIFO_DEPTH));
  assign wr_ok   = adr_ok(wr_adr_i);
  assign rd_ok   = adr_ok(rd_adr_i);

  // On conflict the side that did not win last time goes.
  assign wr_gnt   = wr_req_i & (~rd_elig | (last_gnt == GNT_READ));
  assign rd_gnt   = rd_elig  & (~wr_req_i | (last_gnt == GNT_WRITE));
  assign wr_ack_o = wr_gnt;
  assign rd_ack_o = rd_gnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ram_adr_o    <= '0;
      ram_wr_ena_o <= '0;
      ram_wr_dat_o <= '0;
      ram_rd_ena_o <= 1'b0;
      err_o        <= 1'b0;
      last_gnt     <= GNT_READ;
      vld_pipe     <= '0;
      zero_pipe    <= '0;
    end else begin
      ram_wr_ena_o <= '0;
      ram_rd_ena_o <= 1'b0;
      err_o        <= 1'b0;
      vld_pipe     <= {vld_pipe[STAGES-1:0], rd_gnt};
      zero_pipe    <= {zero_pipe[STAGES-1:0], ~rd_ok};
      if (wr_gnt) begin
        last_gnt <= GNT_WRITE;
        if (wr_ok) begin
          ram_adr_o    <= wr_adr_i;
          ram_wr_ena_o <= wr_msk_i;
          ram_wr_dat_o <= wr_dat_i;
        end else begin
          err_o <= 1'b1;
        end
      end else if (rd_gnt) begin
        last_gnt <= GNT_READ;
        if (rd_ok) begin
          ram_adr_o    <= rd_adr_i;
          ram_rd_ena_o <= 1'b1;
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

  buf_192x128_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DAT_WD),
    .CNT_WD(CNT_WD)
  ) u_fifo (
    .gclk    (gclk),
    .grst_n  (grst_n),
    .push    (vld_pipe[STAGES]),
    .push_dat(zero_pipe[STAGES] ? '0 : ram_rd_dat_i),
    .pop     (rd_rdy_i),
    .head_dat(rd_dat_o),
    .head_vld(rd_val_o),
    .cnt     (fifo_cnt)
  );
endmodule

// File: tb/tb_buf_192x128_arb.sv
module tb_buf_192x128_arb;
  logic         gclk = 1'b0;
  logic         grst_n;
  logic         wr_req_i, rd_req_i, rd_rdy_i;
  logic [7:0]   wr_adr_i, rd_adr_i;
  logic [127:0] wr_msk_i, wr_dat_i;
  logic         wr_ack_o, rd_ack_o, rd_val_o, ram_rd_ena_o, err_o;
  logic [127:0] rd_dat_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_dat_i;
  logic [7:0]   ram_adr_o;

  buf_192x128_arb dut (
    .gclk(gclk), .grst_n(grst_n),
    .wr_req_i(wr_req_i), .wr_adr_i(wr_adr_i), .wr_msk_i(wr_msk_i),
    .wr_dat_i(wr_dat_i), .wr_ack_o(wr_ack_o),
    .rd_req_i(rd_req_i), .rd_adr_i(rd_adr_i), .rd_ack_o(rd_ack_o),
    .rd_val_o(rd_val_o), .rd_dat_o(rd_dat_o), .rd_rdy_i(rd_rdy_i),
    .ram_adr_o(ram_adr_o), .ram_wr_ena_o(ram_wr_ena_o),
    .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_ena_o(ram_rd_ena_o),
    .ram_rd_dat_i(ram_rd_dat_i), .err_o(err_o)
  );

  always #5 gclk = ~gclk;

  // RAM behaviour: bit-enable write at the edge, read data the cycle after.
  logic [127:0] ram [0:191] = '{default: '0};
  logic [127:0] ram_q = '0;
  assign ram_rd_dat_i = ram_q;
  always @(posedge gclk) begin
    if (ram_wr_ena_o != '0 && ram_adr_o < 8'd192)
      ram[ram_adr_o] <= (ram[ram_adr_o] & ~ram_wr_ena_o) | (ram_wr_dat_o & ram_wr_ena_o);
    if (ram_rd_ena_o && ram_adr_o < 8'd192) ram_q <= ram[ram_adr_o];
  end

  // Reference memory updated in grant order; scoreboard of expected returns.
  logic [127:0] ref_mem [0:255] = '{default: '0};
  logic [127:0] sb [$];
  int tests = 0, fails = 0, npop = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge gclk) begin
    if (grst_n) begin
      if (wr_req_i && wr_ack_o && wr_adr_i < 8'd192)
        ref_mem[wr_adr_i] = (ref_mem[wr_adr_i] & ~wr_msk_i) | (wr_dat_i & wr_msk_i);
      if (rd_req_i && rd_ack_o)
        sb.push_back(rd_adr_i < 8'd192 ? ref_mem[rd_adr_i] : 128'h0);
      if (rd_val_o && rd_rdy_i) begin
        npop++;
        if (sb.size() == 0) chk("rd_unexpected", {127'h0, rd_val_o}, 128'h0);
        else chk("rd_dat", rd_dat_o, sb.pop_front());
      end
      chk("ack_excl", {127'h0, wr_ack_o & rd_ack_o}, 128'h0);
      chk("ram_excl", {127'h0, (ram_wr_ena_o != '0) & ram_rd_ena_o}, 128'h0);
    end
  end

  typedef struct {
    logic wr; logic [7:0] wa; logic [127:0] wm, wd;
    logic rd; logic [7:0] ra;
    logic ewa, era; logic [127:0] ewena; logic erena; logic [7:0] eadr; logic eerr;
  } vec_t;
  localparam int NV = 17;
  vec_t tbl [NV];

  function automatic vec_t mk(logic wr, logic [7:0] wa, logic [127:0] wm, logic rd,
                              logic [7:0] ra, logic ewa, logic era, logic [127:0] ewena,
                              logic erena, logic [7:0] eadr, logic eerr);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wm = wm; v.rd = rd; v.ra = ra;
    v.wd = (wa == 8'd5) ? {16{8'hAB}} : {4{24'hC0DE00, wa}};
    v.ewa = ewa; v.era = era; v.ewena = ewena; v.erena = erena;
    v.eadr = eadr; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk_reg(input int j);
    chk($sformatf("v%0d_wr_ena", j), ram_wr_ena_o, tbl[j].ewena);
    chk($sformatf("v%0d_rd_ena", j), {127'h0, ram_rd_ena_o}, {127'h0, tbl[j].erena});
    chk($sformatf("v%0d_adr", j), {120'h0, ram_adr_o}, {120'h0, tbl[j].eadr});
    chk($sformatf("v%0d_err", j), {127'h0, err_o}, {127'h0, tbl[j].eerr});
  endtask

  task automatic idle();
    @(posedge gclk); #1;
    wr_req_i = 1'b0; rd_req_i = 1'b0;
  endtask

  task automatic wr_op(input logic [7:0] a, input logic [127:0] m, input logic [127:0] d);
    int n;
    @(posedge gclk); #1;
    wr_req_i = 1'b1; wr_adr_i = a; wr_msk_i = m; wr_dat_i = d; rd_req_i = 1'b0;
    n = 0;
    @(negedge gclk);
    while (!wr_ack_o && n < 20) begin @(negedge gclk); n++; end
    chk("wr_op_ack", {127'h0, wr_ack_o}, 128'h1);
  endtask

  task automatic rd_op(input logic [7:0] a);
    int n;
    @(posedge gclk); #1;
    rd_req_i = 1'b1; rd_adr_i = a; wr_req_i = 1'b0;
    n = 0;
    @(negedge gclk);
    while (!rd_ack_o && n < 20) begin @(negedge gclk); n++; end
    chk("rd_op_ack", {127'h0, rd_ack_o}, 128'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] ones, ff;
    int k, npop0;
    ones = '1; ff = 128'hFF;
    grst_n = 1'b0; wr_req_i = 0; rd_req_i = 0; rd_rdy_i = 1'b1;
    wr_adr_i = '0; rd_adr_i = '0; wr_msk_i = '0; wr_dat_i = '0;

    tbl[0]  = mk(1, 5,   ff,   0, 0,   1, 0, ff,   0, 5,   0);
    tbl[1]  = mk(0, 0,   '0,   1, 5,   0, 1, '0,   1, 5,   0);
    tbl[2]  = mk(1, 10,  ones, 1, 10,  1, 0, ones, 0, 10,  0);
    tbl[3]  = mk(1, 11,  ones, 1, 10,  0, 1, '0,   1, 10,  0);
    tbl[4]  = mk(1, 11,  ones, 1, 11,  1, 0, ones, 0, 11,  0);
    tbl[5]  = mk(1, 12,  ones, 1, 11,  0, 1, '0,   1, 11,  0);
    tbl[6]  = mk(1, 12,  ones, 1, 12,  1, 0, ones, 0, 12,  0);
    tbl[7]  = mk(1, 13,  ones, 1, 12,  0, 1, '0,   1, 12,  0);
    tbl[8]  = mk(1, 13,  ones, 0, 0,   1, 0, ones, 0, 13,  0);
    tbl[9]  = mk(1, 1,   ones, 0, 0,   1, 0, ones, 0, 1,   0);
    tbl[10] = mk(1, 2,   ones, 0, 0,   1, 0, ones, 0, 2,   0);
    tbl[11] = mk(1, 191, ones, 0, 0,   1, 0, ones, 0, 191, 0);
    tbl[12] = mk(1, 192, ones, 0, 0,   1, 0, '0,   0, 191, 1);
    tbl[13] = mk(0, 0,   '0,   1, 1,   0, 1, '0,   1, 1,   0);
    tbl[14] = mk(0, 0,   '0,   1, 200, 0, 1, '0,   0, 1,   1);
    tbl[15] = mk(0, 0,   '0,   1, 2,   0, 1, '0,   1, 2,   0);
    tbl[16] = mk(0, 0,   '0,   0, 0,   0, 0, '0,   0, 2,   0);

    // reset state
    @(negedge gclk);
    chk("rst_rd_val", {127'h0, rd_val_o}, 128'h0);
    chk("rst_rd_dat", rd_dat_o, 128'h0);
    chk("rst_wr_ena", ram_wr_ena_o, 128'h0);
    chk("rst_wr_dat", ram_wr_dat_o, 128'h0);
    chk("rst_rd_ena", {127'h0, ram_rd_ena_o}, 128'h0);
    chk("rst_adr", {120'h0, ram_adr_o}, 128'h0);
    chk("rst_err", {127'h0, err_o}, 128'h0);
    @(posedge gclk); #1 grst_n = 1'b1;

    // read latency: ack cycle, then rd_val on the third following cycle
    @(posedge gclk); #1 rd_req_i = 1'b1; rd_adr_i = 8'd7;
    @(negedge gclk); chk("lat_ack", {127'h0, rd_ack_o}, 128'h1);
    @(posedge gclk); #1 rd_req_i = 1'b0;
    @(negedge gclk); chk("lat_t1_val", {127'h0, rd_val_o}, 128'h0);
    chk("lat_t1_rd_ena", {127'h0, ram_rd_ena_o}, 128'h1);
    @(negedge gclk); chk("lat_t2_val", {127'h0, rd_val_o}, 128'h0);
    @(negedge gclk); chk("lat_t3_val", {127'h0, rd_val_o}, 128'h1);

    // arbitration / range vectors, registered outputs checked one cycle later
    for (int i = 0; i < NV; i++) begin
      @(posedge gclk); #1;
      wr_req_i = tbl[i].wr; wr_adr_i = tbl[i].wa; wr_msk_i = tbl[i].wm;
      wr_dat_i = tbl[i].wd; rd_req_i = tbl[i].rd; rd_adr_i = tbl[i].ra;
      rd_rdy_i = 1'b1;
      @(negedge gclk);
      chk($sformatf("v%0d_wr_ack", i), {127'h0, wr_ack_o}, {127'h0, tbl[i].ewa});
      chk($sformatf("v%0d_rd_ack", i), {127'h0, rd_ack_o}, {127'h0, tbl[i].era});
      if (i > 0) chk_reg(i - 1);
    end
    @(negedge gclk); chk_reg(NV - 1);
    repeat (5) idle();

    // backpressure: 8 reads with consumer stalled, only 4 accepted
    for (int j = 0; j < 8; j++) wr_op(8'(20 + j), ones, {4{32'h5000_0000 + j}});
    idle();
    npop0 = npop;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge gclk); #1;
      rd_rdy_i = 1'b0; rd_req_i = 1'b1; rd_adr_i = 8'(20 + k);
      @(negedge gclk);
      if (rd_ack_o) k++;
    end
    chk("bp_acks", 128'(k), 128'd4);
    chk("bp_ack_low", {127'h0, rd_ack_o}, 128'h0);
    chk("bp_val", {127'h0, rd_val_o}, 128'h1);
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(posedge gclk); #1;
      rd_rdy_i = 1'b1; rd_req_i = 1'b1; rd_adr_i = 8'(20 + k);
      @(negedge gclk);
      if (rd_ack_o) k++;
    end
    idle();
    chk("bp_resume", 128'(k), 128'd8);
    repeat (6) idle();
    chk("bp_pops", 128'(npop - npop0), 128'd8);

    // reset with 2 reads in flight and 2 words in the FIFO
    for (int c = 0; c < 4; c++) begin
      @(posedge gclk); #1;
      rd_rdy_i = 1'b0; rd_req_i = 1'b1; rd_adr_i = 8'(20 + c);
      @(negedge gclk);
      chk("mr_ack", {127'h0, rd_ack_o}, 128'h1);
    end
    @(posedge gclk); #1;
    grst_n = 1'b0; rd_req_i = 1'b0; sb.delete();
    #1;
    chk("mr_rd_val", {127'h0, rd_val_o}, 128'h0);
    chk("mr_rd_dat", rd_dat_o, 128'h0);
    chk("mr_rd_ena", {127'h0, ram_rd_ena_o}, 128'h0);
    chk("mr_wr_ena", ram_wr_ena_o, 128'h0);
    chk("mr_adr", {120'h0, ram_adr_o}, 128'h0);
    chk("mr_err", {127'h0, err_o}, 128'h0);
    repeat (2) @(posedge gclk);
    #1 grst_n = 1'b1; rd_rdy_i = 1'b1;
    npop0 = npop;
    for (int c = 0; c < 5; c++) begin
      @(negedge gclk);
      chk("mr_no_val", {127'h0, rd_val_o}, 128'h0);
    end
    rd_op(8'd21);
    idle();
    repeat (5) @(negedge gclk);
    chk("mr_new_pop", 128'(npop - npop0), 128'd1);

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
